// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: rotate/shift by B over SHW registered stages.
// Define SHIFTER_FLAGS_EN to add the zero and carry result flags.
module pipelined_barrel_shifter #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [SHW-1:0]   B,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] C
`ifdef SHIFTER_FLAGS_EN
    ,
    output logic             zero,
    output logic             carry
`endif
);

    localparam int LAST = SHW - 1;

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_ROR = 2'b01;
    localparam logic [1:0] OP_SHL = 2'b10;

    logic [WIDTH-1:0] dat_q [SHW];
    logic [WIDTH-1:0] dat_d [SHW];
    logic [SHW-1:0]   vld_q;
    logic [SHW-1:0]   vld_d;
    logic [1:0]       op_q  [LAST];
    logic [1:0]       op_d  [LAST];
    logic [SHW-1:0]   b_q   [LAST];
    logic [SHW-1:0]   b_d   [LAST];

    logic [WIDTH-1:0] src_dat [SHW];
    logic [1:0]       src_op  [SHW];
    logic [SHW-1:0]   src_b   [SHW];
    logic [SHW-1:0]   src_vld;

    logic stall;

    function automatic logic [WIDTH-1:0] shift_by(
        input logic [WIDTH-1:0] x,
        input logic [1:0]       m,
        input int               s
    );
        logic [WIDTH-1:0] r;
        case (m)
            OP_ROL:  r = (x << s) | (x >> (WIDTH - s));
            OP_ROR:  r = (x >> s) | (x << (WIDTH - s));
            OP_SHL:  r = x << s;
            default: r = $unsigned($signed(x) >>> s);
        endcase
        return r;
    endfunction

    assign stall     = vld_q[LAST] & ~out_ready;
    assign in_ready  = rst | ~stall;
    assign out_valid = vld_q[LAST];
    assign C         = dat_q[LAST];

    // Stage k consumes bit k of B; bubbles carry zeroed data so C is 0 when idle.
    always_comb begin
        src_dat[0] = A;
        src_op[0]  = op;
        src_b[0]   = B;
        src_vld[0] = in_valid;
        for (int k = 1; k < SHW; k++) begin
            src_dat[k] = dat_q[k-1];
            src_op[k]  = op_q[k-1];
            src_b[k]   = b_q[k-1];
            src_vld[k] = vld_q[k-1];
        end
        for (int k = 0; k < SHW; k++) begin
            dat_d[k] = '0;
            if (src_vld[k]) begin
                if (src_b[k][k]) begin
                    dat_d[k] = shift_by(src_dat[k], src_op[k], 1 << k);
                end else begin
                    dat_d[k] = src_dat[k];
                end
            end
        end
        vld_d = src_vld;
        for (int k = 0; k < LAST; k++) begin
            op_d[k] = src_vld[k] ? src_op[k] : 2'b00;
            b_d[k]  = src_vld[k] ? src_b[k] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int k = 0; k < SHW; k++) begin
                dat_q[k] <= '0;
            end
            for (int k = 0; k < LAST; k++) begin
                op_q[k] <= 2'b00;
                b_q[k]  <= '0;
            end
        end else if (!stall) begin
            vld_q <= vld_d;
            dat_q <= dat_d;
            op_q  <= op_d;
            b_q   <= b_d;
        end
    end

`ifdef SHIFTER_FLAGS_EN
    logic [SHW-1:0] cy_q;
    logic [SHW-1:0] cy_d;
    logic [SHW-1:0] src_cy;

    // The last stage that actually shifts decides which bit crossed last.
    function automatic logic carry_by(
        input logic [WIDTH-1:0] x,
        input logic [1:0]       m,
        input int               s
    );
        logic [WIDTH-1:0] rl;
        logic [WIDTH-1:0] rr;
        rl = (x << s) | (x >> (WIDTH - s));
        rr = (x >> s) | (x << (WIDTH - s));
        return m[0] ? rr[WIDTH-1] : rl[0];
    endfunction

    always_comb begin
        src_cy[0] = 1'b0;
        for (int k = 1; k < SHW; k++) begin
            src_cy[k] = cy_q[k-1];
        end
        for (int k = 0; k < SHW; k++) begin
            cy_d[k] = 1'b0;
            if (src_vld[k]) begin
                if (src_b[k][k]) begin
                    cy_d[k] = carry_by(src_dat[k], src_op[k], 1 << k);
                end else begin
                    cy_d[k] = src_cy[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cy_q <= '0;
        end else if (!stall) begin
            cy_q <= cy_d;
        end
    end

    assign carry = cy_q[LAST];
    assign zero  = vld_q[LAST] & ~|dat_q[LAST];
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench: WIDTH=16 and WIDTH=8 shifters against a bit-level
// reference model with an in-order scoreboard per instance.
module tb_pipelined_barrel_shifter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        iv16 = 1'b0;
    logic        ir16;
    logic [15:0] a16 = '0;
    logic [3:0]  b16 = '0;
    logic [1:0]  op16 = '0;
    logic        ov16;
    logic        or16 = 1'b1;
    logic [15:0] c16;

    logic        iv8 = 1'b0;
    logic        ir8;
    logic [7:0]  a8 = '0;
    logic [2:0]  b8 = '0;
    logic [1:0]  op8 = '0;
    logic        ov8;
    logic        or8 = 1'b1;
    logic [7:0]  c8;

`ifdef SHIFTER_FLAGS_EN
    logic z16, cy16, z8, cy8;
`endif

    int nchk = 0;
    int nbad = 0;

    typedef struct {
        logic [63:0] a;
        int          b;
        logic [63:0] e;
        logic        cy;
    } exp_t;

    exp_t q16[$];
    exp_t q8[$];

    always #5 clk = ~clk;

    pipelined_barrel_shifter #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(iv16), .in_ready(ir16),
        .A(a16), .B(b16), .op(op16),
        .out_valid(ov16), .out_ready(or16), .C(c16)
`ifdef SHIFTER_FLAGS_EN
        , .zero(z16), .carry(cy16)
`endif
    );

    pipelined_barrel_shifter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(iv8), .in_ready(ir8),
        .A(a8), .B(b8), .op(op8),
        .out_valid(ov8), .out_ready(or8), .C(c8)
`ifdef SHIFTER_FLAGS_EN
        , .zero(z8), .carry(cy8)
`endif
    );

    // Reference: each result bit located by modular index arithmetic.
    function automatic logic [63:0] ref_c(int w, logic [63:0] a, int b, int m);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            case (m)
                0:       r[(i + b) % w] = a[i];
                1:       r[i] = a[(i + b) % w];
                2:       r[i] = (i >= b) ? a[i - b] : 1'b0;
                default: r[i] = (i + b < w) ? a[i + b] : a[w - 1];
            endcase
        end
        return r;
    endfunction

    function automatic logic ref_cy(int w, logic [63:0] a, int b, int m);
        logic [63:0] r;
        if (b == 0) return 1'b0;
        r = ref_c(w, a, b, m);
        case (m)
            0:       return r[0];
            1:       return r[w - 1];
            2:       return a[w - b];
            default: return a[b - 1];
        endcase
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
        nchk++;
        assert (obs === expv) else begin
            nbad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic timeout(string tag);
        nchk++;
        nbad++;
        $error("FAIL %s: observed timeout expected event", tag);
    endtask

    logic        pst16 = 1'b0;
    logic [15:0] pc16 = '0;
    always @(negedge clk) begin
        exp_t it;
        if (ov16 === 1'b1 && or16) begin
            if (q16.size() == 0) begin
                timeout("stale16");
            end else begin
                it = q16.pop_front();
                check("res16", 64'(c16), 64'(it.e[15:0]));
                if (it.b == 0) check("b0_16", 64'(c16), 64'(it.a[15:0]));
`ifdef SHIFTER_FLAGS_EN
                check("carry16", 64'(cy16), 64'(it.cy));
                check("zero16", 64'(z16), 64'(it.e[15:0] == 16'h0));
`endif
            end
        end
        if (ov16 === 1'b0) check("idleC16", 64'(c16), 64'h0);
        if (pst16) check("hold16", 64'(c16), 64'(pc16));
        if (!rst) check("rdy16", 64'(ir16), 64'(!(ov16 && !or16)));
        pst16 = (ov16 === 1'b1) && !or16 && !rst;
        pc16  = c16;
        if (rst) q16.delete();
        else if (iv16 && ir16) begin
            it.a  = 64'(a16);
            it.b  = int'(b16);
            it.e  = ref_c(16, 64'(a16), int'(b16), int'(op16));
            it.cy = ref_cy(16, 64'(a16), int'(b16), int'(op16));
            q16.push_back(it);
        end
    end

    always @(negedge clk) begin
        exp_t it;
        if (ov8 === 1'b1 && or8) begin
            if (q8.size() == 0) begin
                timeout("stale8");
            end else begin
                it = q8.pop_front();
                check("res8", 64'(c8), 64'(it.e[7:0]));
                if (it.b == 0) check("b0_8", 64'(c8), 64'(it.a[7:0]));
`ifdef SHIFTER_FLAGS_EN
                check("carry8", 64'(cy8), 64'(it.cy));
                check("zero8", 64'(z8), 64'(it.e[7:0] == 8'h0));
`endif
            end
        end
        if (ov8 === 1'b0) check("idleC8", 64'(c8), 64'h0);
        if (rst) q8.delete();
        else if (iv8 && ir8) begin
            it.a  = 64'(a8);
            it.b  = int'(b8);
            it.e  = ref_c(8, 64'(a8), int'(b8), int'(op8));
            it.cy = ref_cy(8, 64'(a8), int'(b8), int'(op8));
            q8.push_back(it);
        end
    end

    task automatic issue16(logic [15:0] a, int b, int m);
        bit acc;
        acc  = 1'b0;
        a16  = a;
        b16  = 4'(b);
        op16 = 2'(m);
        iv16 = 1'b1;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = ir16;
            @(posedge clk);
            #1;
        end
        iv16 = 1'b0;
        if (!acc) timeout("accept16");
    endtask

    task automatic issue8(logic [7:0] a, int b, int m);
        bit acc;
        acc = 1'b0;
        a8  = a;
        b8  = 3'(b);
        op8 = 2'(m);
        iv8 = 1'b1;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = ir8;
            @(posedge clk);
            #1;
        end
        iv8 = 1'b0;
        if (!acc) timeout("accept8");
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q16.size() != 0 || q8.size() != 0) && t < 500) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (t >= 500) timeout("drain");
    endtask

    initial begin
        int cnt;
        bit done;

        // In-flight request during reset must be ignored.
        iv16 = 1'b1;
        a16  = 16'hBEEF;
        b16  = 4'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ov16", 64'(ov16), 64'h0);
        check("rst_C16", 64'(c16), 64'h0);
        check("rst_ir16", 64'(ir16), 64'h1);
        check("rst_ov8", 64'(ov8), 64'h0);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        iv16 = 1'b0;

        // Latency: edges counted from the accepting edge until out_valid.
        a16  = 16'h8001;
        b16  = 4'd1;
        op16 = 2'b00;
        iv16 = 1'b1;
        @(posedge clk);
        #1;
        iv16 = 1'b0;
        cnt  = 1;
        @(negedge clk);
        while (!ov16 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("latency", 64'(cnt), 64'd4);
        check("lat_C", 64'(c16), 64'h0003);
        drain();

        issue16(16'h0001, 4, 1);
        issue16(16'h00FF, 8, 2);
        issue16(16'h8000, 15, 3);
        cnt = 0;
        @(negedge clk);
        while (!ov16 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("b2b_0", 64'(c16), 64'h1000);
        @(negedge clk);
        check("b2b_1", 64'(c16), 64'hFF00);
        @(negedge clk);
        check("b2b_2", 64'(c16), 64'hFFFF);
        drain();

        // Output stall for 6 cycles with 5 operations issued.
        fork
            begin
                for (int i = 0; i < 5; i++) issue16(16'($urandom), i + 1, i % 4);
            end
            begin
                or16 = 1'b0;
                repeat (5) @(posedge clk);
                @(negedge clk);
                check("stall_ov", 64'(ov16), 64'h1);
                check("stall_ir", 64'(ir16), 64'h0);
                @(posedge clk);
                #1;
                or16 = 1'b1;
            end
        join
        drain();

        // Reset with three operations in flight.
        issue16(16'h1234, 1, 0);
        issue16(16'h5678, 2, 1);
        issue16(16'h9ABC, 3, 2);
        rst  = 1'b1;
        iv16 = 1'b1;
        a16  = 16'h7777;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        iv16 = 1'b0;
        @(negedge clk);
        check("rst_mid_ov", 64'(ov16), 64'h0);
        check("rst_mid_C", 64'(c16), 64'h0);
        check("rst_mid_ir", 64'(ir16), 64'h1);
        repeat (8) @(posedge clk);
        #1;

        // Exhaustive op/B sweep with random operands.
        for (int m = 0; m < 4; m++)
            for (int b = 0; b < 16; b++) issue16(16'($urandom), b, m);
        issue16(16'h0001, 1, 1);
        issue16(16'h0000, 5, 2);
        for (int m = 0; m < 4; m++)
            for (int b = 0; b < 8; b++) issue8(8'($urandom), b, m);
        issue8(8'h01, 1, 1);
        issue8(8'h80, 7, 3);
        drain();

        // Random traffic with random back-pressure and input gaps.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    issue16(16'($urandom), int'($urandom_range(0, 15)),
                            int'($urandom_range(0, 3)));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    or16 = ($urandom_range(0, 2) != 0);
                    @(posedge clk);
                    #1;
                end
                or16 = 1'b1;
            end
        join
        drain();
        repeat (6) @(posedge clk);
        #1;
        check("q16_empty", 64'(q16.size()), 64'h0);
        check("q8_empty", 64'(q8.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nbad);
        $finish;
    end

endmodule

// File: doc/pipelined_barrel_shifter.md
PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, data width in bits; legal values are powers of two from 4 to 64.
REQ-002 The block SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width; it is derived and never overridden.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1, operand valid.
REQ-006 The block SHALL have port in_ready, output, 1, block accepts an operand this cycle.
REQ-007 The block SHALL have port A, input, WIDTH, operand.
REQ-008 The block SHALL have port B, input, SHW, shift amount, 0..WIDTH-1.
REQ-009 The block SHALL have port op, input, 2, mode: 00 rotate left, 01 rotate right, 10 logical shift left, 11 arithmetic shift right.
REQ-010 The block SHALL have port out_valid, output, 1, result valid.
REQ-011 The block SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-012 The block SHALL have port C, output, WIDTH, result.

Function
REQ-013 A transfer in SHALL occur when in_valid and in_ready are both high on a clock edge; a transfer out SHALL occur when out_valid and out_ready are both high.
REQ-014 The datapath SHALL be SHW registered stages; stage k applies a shift of 2^k when B[k]=1 and passes data otherwise, carrying op, B and valid alongside the data.
REQ-015 Latency SHALL be exactly SHW cycles from the accepting edge to out_valid high when there is no stall, e.g. 4 cycles at WIDTH=16.
REQ-016 Throughput SHALL be one operation per cycle while out_ready stays high.
REQ-017 The stall condition is out_valid and not out_ready; during a stall every stage SHALL hold its contents and in_ready SHALL be low.
REQ-018 in_ready SHALL equal the negation of the stall condition and SHALL never depend combinationally on in_valid.
REQ-019 While out_valid is high and out_ready is low, C SHALL remain stable.
REQ-020 Rotate modes SHALL wrap bits across the boundary with no loss.
REQ-021 Logical shift left SHALL fill vacated positions with 0.
REQ-022 Arithmetic shift right SHALL fill vacated positions with A[WIDTH-1].
REQ-023 B=0 SHALL return A unchanged in every mode.
REQ-024 Bubbles, meaning stages with valid=0, SHALL propagate and be squeezed out only by normal advance; the block SHALL never drop or duplicate a transfer.
REQ-025 C SHALL be 0 whenever out_valid is 0.

Reset
REQ-026 While rst is high at a clock edge, all stage valid bits, out_valid and C SHALL clear to 0; in_ready SHALL read 1 during and after reset.
REQ-027 Reset mid-operation SHALL discard all in-flight operations with no output produced for them.
REQ-028 An in_valid asserted in the same cycle as rst SHALL NOT be accepted.

Configuration
REQ-029 With macro SHIFTER_FLAGS_EN defined, the block SHALL add output ports zero (1 bit, high when C is 0) and carry (1 bit), both aligned with out_valid.
REQ-030 With SHIFTER_FLAGS_EN defined, carry SHALL be the last bit moved across the boundary: rotate left gives C[0], rotate right gives C[WIDTH-1], shift left gives A[WIDTH-B], arithmetic shift right gives A[B-1]; carry SHALL be 0 when B=0, and zero and carry SHALL reset to 0.
REQ-031 Without SHIFTER_FLAGS_EN, the zero and carry ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 WIDTH=16, out_ready=1, A=0x8001, B=1, op=00 -> C=0x0003 with out_valid exactly 4 cycles after acceptance.
REQ-033 Back-to-back inputs, one per cycle: (0x0001, B=4, op=01), (0x00FF, B=8, op=10), (0x8000, B=15, op=11) -> C=0x1000, 0xFF00, 0xFFFF on consecutive cycles; with flags, carries are 0, 0, 0.
REQ-034 Hold out_ready=0 for 6 cycles with 5 operations issued -> in_ready drops once out_valid is high, C stays stable, and all 5 results emerge in order after release with none lost.
REQ-035 Assert rst for 1 cycle while 3 operations are in flight -> out_valid=0 and C=0 next cycle, and no stale result ever appears.
REQ-036 Exhaustive sweep of WIDTH=16 and WIDTH=8, all op values, all B values, random A -> C matches the reference model and B=0 returns A; with SHIFTER_FLAGS_EN, A=0x0001, B=1, op=01 -> C=0x8000, carry=1, zero=0.
